// File: rtl/fnc_vram_pkg.sv
// Shared definitions for the VRAM arbiter: default widths and the arbiter FSM encoding.
package fnc_vram_pkg;

  localparam int VRAM_ADDR_W      = 20;
  localparam int VRAM_DATA_W      = 12;
  localparam int VRAM_WFIFO_DEPTH = 4;

  // Arbiter phases: rest, drain buffered writes, issue a CPU read, return read data.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RWAIT = 2'd3
  } arbState_e;

endpackage

// File: rtl/fnc_vram_wfifo.sv
// CPU write buffer: small synchronous FIFO holding {address, data} pairs.
// A push while full and a pop while empty are both ignored.
module fnc_vram_wfifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] popData_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             doPush;
  logic             doPop;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign doPush    = push_i & ~full_o;
  assign doPop     = pop_i & ~empty_o;
  assign popData_o = mem_q[rdPtr_q];
  assign count_o   = count_q;

  // Occupancy next-state: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    if (doPush && !doPop) begin
      count_d = count_q + CNT_W'(1);
    end else if (doPop && !doPush) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers; reset discards every buffered entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // Entry storage; no reset because the occupancy count gates every read.
  always_ff @(posedge clk_i) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= pushData_i;
    end
  end

endmodule

// File: rtl/fnc_vram_arbiter.sv
// Single-port VRAM arbiter: the display always wins the RAM port while it is
// actively scanning; CPU writes are buffered and drained during blanking
// (or whenever the display is disabled), then a pending CPU read is served.
module fnc_vram_arbiter
  import fnc_vram_pkg::*;
#(
  parameter int ADDR_W      = VRAM_ADDR_W,
  parameter int DATA_W      = VRAM_DATA_W,
  parameter int WFIFO_DEPTH = VRAM_WFIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              module_en,
  input  logic              hbrank,
  input  logic              vbrank,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_waddr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_wready,
  input  logic              cpu_re,
  input  logic [ADDR_W-1:0] cpu_raddr,
  output logic              cpu_rbusy,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(WFIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ONE = CNT_W'(1);

  arbState_e         state_q;
  logic              dispGrant;
  logic              dispValid_q;
  logic              rbusy_q;
  logic [ADDR_W-1:0] raddr_q;
  logic [DATA_W-1:0] rdata_q;

  logic              fifoPush;
  logic              fifoPop;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [CNT_W-1:0]  fifoCount;
  logic [ENTRY_W-1:0] fifoHead;
  logic [ADDR_W-1:0] headAddr;
  logic [DATA_W-1:0] headData;

  assign dispGrant = module_en & ~hbrank & ~vbrank;

  assign fifoPush = cpu_we & ~fifoFull;
  assign fifoPop  = (state_q == ST_WRITE) & ~dispGrant & ~fifoEmpty;
  assign headAddr = fifoHead[ENTRY_W-1:DATA_W];
  assign headData = fifoHead[DATA_W-1:0];

  fnc_vram_wfifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (WFIFO_DEPTH)
  ) u_wfifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_i     (fifoPush),
    .pushData_i ({cpu_waddr, cpu_wdata}),
    .pop_i      (fifoPop),
    .popData_o  (fifoHead),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .count_o    (fifoCount)
  );

  assign cpu_wready = ~fifoFull;
  assign cpu_rbusy  = rbusy_q;
  assign cpu_rvalid = (state_q == ST_RWAIT);
  // The RAM data is already valid during RWAIT, so it is forwarded on the
  // pulse cycle and the latched copy is held afterwards.
  assign cpu_rdata  = cpu_rvalid ? ram_rdata : rdata_q;
  assign disp_data  = dispValid_q ? ram_rdata : '0;

  // Remember whether the display owned the port last cycle (1-cycle RAM latency).
  always_ff @(posedge clk) begin
    if (rst) begin
      dispValid_q <= 1'b0;
    end else begin
      dispValid_q <= dispGrant;
    end
  end

  // Arbiter FSM plus CPU read request capture and read-data latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rbusy_q <= 1'b0;
      raddr_q <= '0;
      rdata_q <= '0;
    end else begin
      if (cpu_re && !rbusy_q) begin
        rbusy_q <= 1'b1;
        raddr_q <= cpu_raddr;
      end
      case (state_q)
        ST_IDLE: begin
          if (!dispGrant) begin
            if (!fifoEmpty) begin
              state_q <= ST_WRITE;
            end else if (rbusy_q) begin
              state_q <= ST_READ;
            end
          end
        end
        ST_WRITE: begin
          if (dispGrant || fifoEmpty || (fifoCount == LAST_ONE)) begin
            state_q <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (!dispGrant) begin
            state_q <= ST_RWAIT;
          end
        end
        ST_RWAIT: begin
          rdata_q <= ram_rdata;
          rbusy_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // RAM port mux: display first, otherwise whatever the FSM is doing this cycle.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (dispGrant) begin
      ram_addr = disp_addr;
    end else begin
      case (state_q)
        ST_WRITE: begin
          if (!fifoEmpty) begin
            ram_addr  = headAddr;
            ram_we    = 1'b1;
            ram_wdata = headData;
          end
        end
        ST_READ: ram_addr = raddr_q;
        default: ;
      endcase
    end
  end

endmodule
